// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for the single-precision adder/subtractor.
`default_nettype none

interface fp_addsub_if;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_op;
    logic        input_stb;
    logic        input_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_b, input_op, input_stb, output_z_ack,
        input  input_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_b, input_op, input_stb, output_z_ack,
        output input_ack, output_z, output_z_stb
    );
endinterface

`default_nettype wire

// File: rtl/fp_addsub.sv
// IEEE-754 single-precision add/subtract, multi-cycle FSM, RNE rounding, flush-to-zero.
`default_nettype none

module fp_addsub (
    input wire          clk,
    input wire          rst,
    fp_addsub_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
    } state_t;

    state_t             r_state;
    logic [31:0]        r_a, r_b;
    logic               r_op;
    logic               r_a_s, r_b_s;
    logic [7:0]         r_a_e, r_b_e;
    logic [23:0]        r_a_m, r_b_m;
    logic [26:0]        r_a_al, r_b_al;
    logic [27:0]        r_sum;
    logic               r_s;
    logic signed [9:0]  r_e;
    logic [26:0]        r_m;
    logic               r_ack, r_z_stb;
    logic [31:0]        r_z;

    // Right shift keeping everything shifted out as a sticky bit in bit 0.
    function automatic logic [26:0] f_shr_sticky(input logic [26:0] m, input logic [7:0] d);
        logic [26:0] mask;
        if (d >= 8'd26) begin
            return {26'b0, |m};
        end
        mask = ~(27'h7FFFFFF << d);
        return (m >> d) | {26'b0, |(m & mask)};
    endfunction

    function automatic logic [4:0] f_lzc(input logic [26:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic               w_a_big;
    logic [26:0]        w_shifted;
    logic [4:0]         w_lz;
    logic               w_up;
    logic [24:0]        w_rnd;
    logic signed [9:0]  w_e_fin;
    logic [22:0]        w_frac;
    logic [31:0]        w_z_fin;

    always_comb begin
        w_a_nan   = (r_a_e == 8'hFF) && (r_a_m[22:0] != 23'd0);
        w_b_nan   = (r_b_e == 8'hFF) && (r_b_m[22:0] != 23'd0);
        w_a_inf   = (r_a_e == 8'hFF) && (r_a_m[22:0] == 23'd0);
        w_b_inf   = (r_b_e == 8'hFF) && (r_b_m[22:0] == 23'd0);
        w_a_big   = (r_a_e >= r_b_e);
        w_shifted = w_a_big ? f_shr_sticky({r_b_m, 3'b0}, r_a_e - r_b_e)
                            : f_shr_sticky({r_a_m, 3'b0}, r_b_e - r_a_e);
        w_lz      = f_lzc(r_sum[26:0]);
        w_up      = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        w_rnd     = {1'b0, r_m[26:3]} + {24'b0, w_up};
        w_e_fin   = w_rnd[24] ? r_e + 10'sd1 : r_e;
        w_frac    = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
        if (r_m == 27'd0)             w_z_fin = {r_s, 31'b0};
        else if (w_e_fin >= 10'sd255) w_z_fin = {r_s, 8'hFF, 23'b0};
        else if (w_e_fin <= 10'sd0)   w_z_fin = {r_s, 31'b0};
        else                          w_z_fin = {r_s, w_e_fin[7:0], w_frac};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 1'b0;
            r_a_s   <= 1'b0;
            r_b_s   <= 1'b0;
            r_a_e   <= 8'd0;
            r_b_e   <= 8'd0;
            r_a_m   <= 24'd0;
            r_b_m   <= 24'd0;
            r_a_al  <= 27'd0;
            r_b_al  <= 27'd0;
            r_sum   <= 28'd0;
            r_s     <= 1'b0;
            r_e     <= 10'sd0;
            r_m     <= 27'd0;
            r_ack   <= 1'b1;
            r_z_stb <= 1'b0;
            r_z     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.input_stb && r_ack) begin
                        r_a     <= bus.input_a;
                        r_b     <= bus.input_b;
                        r_op    <= bus.input_op;
                        r_ack   <= 1'b0;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_a_s   <= r_a[31];
                    r_b_s   <= r_b[31] ^ r_op;
                    r_a_e   <= r_a[30:23];
                    r_b_e   <= r_b[30:23];
                    r_a_m   <= (r_a[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
                    r_b_m   <= (r_b[30:23] == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
                    r_state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    r_state <= S_OUT;
                    r_z_stb <= 1'b1;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a_s != r_b_s)))
                        r_z <= 32'h7FC00000;
                    else if (w_a_inf)
                        r_z <= {r_a_s, 8'hFF, 23'b0};
                    else if (w_b_inf)
                        r_z <= {r_b_s, 8'hFF, 23'b0};
                    else if (r_a_e == 8'd0 && r_b_e == 8'd0)
                        r_z <= {r_a_s & r_b_s, 31'b0};
                    else begin
                        r_state <= S_ALIGN;
                        r_z_stb <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    r_a_al  <= w_a_big ? {r_a_m, 3'b0} : w_shifted;
                    r_b_al  <= w_a_big ? w_shifted : {r_b_m, 3'b0};
                    r_e     <= w_a_big ? signed'({2'b0, r_a_e}) : signed'({2'b0, r_b_e});
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (r_a_s == r_b_s) begin
                        r_sum <= {1'b0, r_a_al} + {1'b0, r_b_al};
                        r_s   <= r_a_s;
                    end else if (r_a_al >= r_b_al) begin
                        r_sum <= {1'b0, r_a_al - r_b_al};
                        r_s   <= (r_a_al == r_b_al) ? 1'b0 : r_a_s;
                    end else begin
                        r_sum <= {1'b0, r_b_al - r_a_al};
                        r_s   <= r_b_s;
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sum[27]) begin
                        r_m <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                        r_e <= r_e + 10'sd1;
                    end else begin
                        r_m <= r_sum[26:0] << w_lz;
                        r_e <= r_e - signed'({5'b0, w_lz});
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_z     <= w_z_fin;
                    r_z_stb <= 1'b1;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.input_ack    = r_ack;
    assign bus.output_z     = r_z;
    assign bus.output_z_stb = r_z_stb;

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: directed vectors, decoupled monitor with backpressure.
`timescale 1ns/1ps
`default_nettype none

module tb_fp_addsub;
    logic clk = 1'b0;
    logic rst;
    fp_addsub_if bus();

    fp_addsub dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] z;
        int          lat;
        int          t_edge;
        int          hold;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call just after a posedge; transfers on the next edge where input_ack is high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] z, input int lat, input int hold);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.input_ack !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("input_ack_timeout", {31'b0, bus.input_ack}, 32'd1);
            return;
        end
        bus.input_a   = a;
        bus.input_b   = b;
        bus.input_op  = op;
        bus.input_stb = 1'b1;
        e.z      = z;
        e.lat    = lat;
        e.t_edge = cyc + 1;
        e.hold   = hold;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.input_stb = 1'b0;
        bus.input_a   = 32'hDEADBEEF;
        bus.input_b   = 32'h12345678;
        bus.input_op  = ~op;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || mon_busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] z0;
        bus.output_z_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.output_z_stb === 1'b1) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_stb", {31'b0, bus.output_z_stb}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.output_z, e.z);
                    check("latency", cyc - e.t_edge, e.lat);
                    z0 = bus.output_z;
                    for (int k = 0; k < e.hold; k++) begin
                        @(negedge clk);
                        check("bp_stb", {31'b0, bus.output_z_stb}, 32'd1);
                        check("bp_z_stable", bus.output_z, z0);
                        check("bp_input_ack", {31'b0, bus.input_ack}, 32'd0);
                    end
                    bus.output_z_ack = 1'b1;
                    @(negedge clk);
                    bus.output_z_ack = 1'b0;
                    check("stb_after_ack", {31'b0, bus.output_z_stb}, 32'd0);
                    check("input_ack_after_ack", {31'b0, bus.input_ack}, 32'd1);
                    check("z_kept_in_idle", bus.output_z, e.z);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin : stim
        rst           = 1'b0;
        bus.input_a   = 32'd0;
        bus.input_b   = 32'd0;
        bus.input_op  = 1'b0;
        bus.input_stb = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_input_ack", {31'b0, bus.input_ack}, 32'd1);
        check("reset_stb", {31'b0, bus.output_z_stb}, 32'd0);
        check("reset_z", bus.output_z, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        send(32'h41A00000, 32'h40000000, 1'b0, 32'h41B00000, 6, 0);
        send(32'hC1200000, 32'h40000000, 1'b1, 32'hC1400000, 6, 0);
        send(32'hC27C0000, 32'h427C0000, 1'b0, 32'h00000000, 6, 0);
        send(32'h41A00000, 32'h41A00000, 1'b1, 32'h00000000, 6, 0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 6, 0);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 6, 0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 6, 0);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2, 0);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2, 0);
        send(32'hFF800000, 32'h41200000, 1'b0, 32'hFF800000, 2, 0);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6, 10);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2, 0);
        send(32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 2, 0);
        send(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 2, 0);
        send(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 6, 0);
        send(32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 6, 0);
        send(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 6, 0);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 6, 0);
        drain();

        // Launch an operation and pull reset while it sits in ALIGN.
        @(negedge clk);
        bus.input_a   = 32'h41A00000;
        bus.input_b   = 32'h40000000;
        bus.input_op  = 1'b0;
        bus.input_stb = 1'b1;
        @(posedge clk);
        #1 bus.input_stb = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_stb", {31'b0, bus.output_z_stb}, 32'd0);
        check("midrst_input_ack", {31'b0, bus.input_ack}, 32'd1);
        check("midrst_z", bus.output_z, 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_hold_stb", {31'b0, bus.output_z_stb}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 6, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
